stm_source_switcher: RTL and testbench
======================================

# stm_source_switcher

Registered, state-machine-controlled selector between the normal-mode and STM-mode duty/phase arrays for all transducers. It sits between `normal_operator`/`stm_operator` and `modulator`, and replaces the combinational duty/phase mux and the single `stm_begin` flag. It generalises that logic in two ways:
- Entry into STM can be gated on a start index, and exit from STM can also be gated on a finish index.
- All channels switch atomically on one clock edge, with registered outputs and a switch-event pulse for GPIO debug.

## Interface
Parameters:
- WIDTH, 13, bit width of each duty/phase value
- DEPTH, 249, number of transducer channels
- IDX_W, 16, width of STM index and start/finish index

Ports:
- CLK  input  1  system clock (`clk_l` domain)
- RESET  input  1  synchronous, active-high reset
- OP_MODE  input  1  1 = STM requested, 0 = normal requested
- USE_START_IDX  input  1  gate STM entry on STM_START_IDX
- START_IDX  input  IDX_W  STM index at which entry occurs
- USE_FINISH_IDX  input  1  gate STM exit on STM_FINISH_IDX
- FINISH_IDX  input  IDX_W  STM index at which exit occurs
- STM_DONE  input  1  one-cycle pulse: STM output updated to STM_IDX
- STM_IDX  input  IDX_W  current STM index, valid with STM_DONE
- DUTY_NORMAL, PHASE_NORMAL  input  WIDTH x DEPTH  normal-mode arrays
- DUTY_STM, PHASE_STM  input  WIDTH x DEPTH  STM-mode arrays
- DUTY, PHASE  output  WIDTH x DEPTH  selected arrays, registered
- STM_ACTIVE  output  1  1 while outputs are sourced from STM
- SWITCH  output  1  one-cycle pulse on the edge where the source changes
- STATE  output  2  FSM state, for debug

## Operation
- States (encoding): NORMAL=0, WAIT_START=1, STM=2, WAIT_FINISH=3. Source is STM in STM and WAIT_FINISH, normal otherwise.
- `hit_s` = STM_DONE & (STM_IDX == START_IDX). `hit_f` = STM_DONE & (STM_IDX == FINISH_IDX). Comparisons are full IDX_W, unsigned.
- Transitions, first matching rule wins:
  - NORMAL:
    - OP_MODE & ~USE_START_IDX → STM
    - OP_MODE & USE_START_IDX → WAIT_START
  - WAIT_START:
    - ~OP_MODE → NORMAL
    - USE_START_IDX=0 → STM
    - hit_s → STM
  - STM:
    - ~OP_MODE & (~USE_FINISH_IDX | hit_f) → NORMAL
    - ~OP_MODE → WAIT_FINISH
  - WAIT_FINISH:
    - OP_MODE → STM (exit cancelled)
    - USE_FINISH_IDX=0 → NORMAL
    - hit_f → NORMAL
  - Any state not listed under a rule holds.
- Output register: on every edge, for each channel i, DUTY[i]/PHASE[i] load the STM or normal input according to the source of the next state. The new source therefore takes effect on the same edge as the state change, with no mixed-source cycle.
- STM_ACTIVE is registered and equals "source of current state is STM".
- SWITCH is registered and is 1 for exactly the one cycle after an edge where STM_ACTIVE changed.
- Config inputs (USE_*, START_IDX, FINISH_IDX) are treated as quasi-static. They are sampled every cycle with no capture.
- An unreachable START_IDX or FINISH_IDX (≥ STM cycle length) is legal:
  - the FSM waits indefinitely;
  - dropping OP_MODE releases WAIT_START;
  - raising OP_MODE releases WAIT_FINISH.

## Timing
- Reset values: state NORMAL, all DUTY/PHASE = 0, STM_ACTIVE=0, SWITCH=0, STATE=0.
- RESET overrides all other inputs, including mid-switch.
- Data latency is 1 cycle. Input arrays sampled at edge t appear on DUTY/PHASE after edge t.
- Switch latency is 1 cycle. If a trigger (OP_MODE level, or hit_s/hit_f) is present before edge t, the new source's data is on the outputs after edge t. STM_ACTIVE and SWITCH change after the same edge.
- Simultaneous events:
  - ~OP_MODE together with hit_s in WAIT_START → NORMAL.
  - ~OP_MODE together with hit_f in STM → NORMAL directly; WAIT_FINISH is skipped.
- NORMAL→STM→NORMAL in consecutive cycles produces two SWITCH pulses on consecutive cycles.

## Test plan
- Reset, then OP_MODE=1 with USE_START_IDX=0 → after one edge: STATE=2, STM_ACTIVE=1, SWITCH=1 for 1 cycle, DUTY[0..248] equal DUTY_STM.
- USE_START_IDX=1, START_IDX=5, OP_MODE=1, STM_DONE pulses with IDX 3,4,5 → STATE=1 until the IDX=5 pulse, STATE=2 after it; outputs stay on normal data until that edge.
- In STM with USE_FINISH_IDX=1, FINISH_IDX=0, drop OP_MODE → STATE=3 and outputs still STM. STM_DONE with IDX=0 → STATE=0, SWITCH pulse, outputs return to normal.
- WAIT_FINISH, then OP_MODE re-raised before the hit → STATE=2, no SWITCH pulse, STM_ACTIVE stays 1.
- WAIT_START with ~OP_MODE and hit_s in the same cycle → STATE=0, STM_ACTIVE=0, no SWITCH.
- Assert RESET while in STM with non-zero arrays → next cycle all outputs 0 and STATE=0. Release RESET with OP_MODE=1 → STM is re-entered one edge later.

Source files
------------

// File: rtl/stm_source_switcher_if.sv
// ---------------------------------------------------------------------------
// stm_source_switcher_if
//
// Bundles the mode/index controls, the two pairs of input arrays and the
// selected outputs of stm_source_switcher.
//
//   slave  modport (the switcher): receives the controls and both array pairs,
//                                  drives duty/phase, stmActive, switchPulse
//                                  and state.
//   master modport (the driver):   the reverse view.
//
// Signals:
//   opMode        1 = STM requested, 0 = normal requested
//   useStartIdx   gate STM entry on startIdx
//   startIdx      STM index at which entry occurs
//   useFinishIdx  gate STM exit on finishIdx
//   finishIdx     STM index at which exit occurs
//   stmDone       one-cycle pulse: STM output updated to stmIdx
//   stmIdx        current STM index, valid with stmDone
//   dutyNormal / phaseNormal   normal-mode arrays
//   dutyStm / phaseStm         STM-mode arrays
//   duty / phase               selected arrays, registered
//   stmActive     1 while outputs are sourced from STM
//   switchPulse   one-cycle pulse after the edge where the source changed
//   state         FSM state, for debug
// ---------------------------------------------------------------------------
interface stm_source_switcher_if #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249,
    parameter int IDX_W = 16
) ();

    logic             opMode;
    logic             useStartIdx;
    logic [IDX_W-1:0] startIdx;
    logic             useFinishIdx;
    logic [IDX_W-1:0] finishIdx;
    logic             stmDone;
    logic [IDX_W-1:0] stmIdx;

    logic [WIDTH-1:0] dutyNormal  [DEPTH];
    logic [WIDTH-1:0] phaseNormal [DEPTH];
    logic [WIDTH-1:0] dutyStm     [DEPTH];
    logic [WIDTH-1:0] phaseStm    [DEPTH];

    logic [WIDTH-1:0] duty        [DEPTH];
    logic [WIDTH-1:0] phase       [DEPTH];
    logic             stmActive;
    logic             switchPulse;
    logic [1:0]       state;

    modport slave (
        input  opMode, useStartIdx, startIdx, useFinishIdx, finishIdx,
        input  stmDone, stmIdx,
        input  dutyNormal, phaseNormal, dutyStm, phaseStm,
        output duty, phase, stmActive, switchPulse, state
    );

    modport master (
        output opMode, useStartIdx, startIdx, useFinishIdx, finishIdx,
        output stmDone, stmIdx,
        output dutyNormal, phaseNormal, dutyStm, phaseStm,
        input  duty, phase, stmActive, switchPulse, state
    );

endinterface

// File: rtl/stm_source_switcher.sv
// ---------------------------------------------------------------------------
// stm_source_switcher
//
// Registered selector between the normal-mode and STM-mode duty/phase arrays.
// A four-state FSM decides which source feeds the modulator. Entry into STM
// can wait for a chosen STM index, and so can the exit back to normal. Every
// channel changes source on the same clock edge. The output registers are
// loaded from the source of the *next* state, so the data follows the state
// change on that same edge and no cycle ever mixes the two sources.
//
// Ports:
//   clk_i    system clock (clk_l domain)
//   reset_i  synchronous, active-high reset
//   bus      stm_source_switcher_if.slave: controls, both input array pairs,
//            selected outputs, stmActive, switchPulse and state
//
// WIDTH/DEPTH/IDX_W must match the parameters of the connected interface.
// ---------------------------------------------------------------------------
module stm_source_switcher #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249,
    parameter int IDX_W = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    stm_source_switcher_if.slave bus
);

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        WAIT_START  = 2'd1,
        STM         = 2'd2,
        WAIT_FINISH = 2'd3
    } stateT;

    stateT            state_q;
    stateT            state_d;
    logic             srcStm_d;
    logic             stmActive_q;
    logic             switch_q;
    logic [WIDTH-1:0] duty_q  [DEPTH];
    logic [WIDTH-1:0] phase_q [DEPTH];

    logic [IDX_W-1:0] stmIdx;
    logic [IDX_W-1:0] startIdx;
    logic [IDX_W-1:0] finishIdx;
    logic             hitStart;
    logic             hitFinish;

    assign stmIdx    = bus.stmIdx;
    assign startIdx  = bus.startIdx;
    assign finishIdx = bus.finishIdx;

    // An index hit only counts on the cycle the STM operator reports that it
    // has moved to that index.
    assign hitStart  = bus.stmDone && (stmIdx == startIdx);
    assign hitFinish = bus.stmDone && (stmIdx == finishIdx);

    // Next-state logic. The order of the checks in each state matters: a
    // dropped opMode beats a simultaneous start hit, and a finish hit that
    // arrives together with the opMode drop skips WAIT_FINISH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (bus.opMode && !bus.useStartIdx) begin
                    state_d = STM;
                end else if (bus.opMode) begin
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (!bus.opMode) begin
                    state_d = NORMAL;
                end else if (!bus.useStartIdx || hitStart) begin
                    state_d = STM;
                end
            end
            STM: begin
                if (!bus.opMode && (!bus.useFinishIdx || hitFinish)) begin
                    state_d = NORMAL;
                end else if (!bus.opMode) begin
                    state_d = WAIT_FINISH;
                end
            end
            WAIT_FINISH: begin
                if (bus.opMode) begin
                    state_d = STM;
                end else if (!bus.useFinishIdx || hitFinish) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // The data source follows the state being entered, not the one being left.
    assign srcStm_d = (state_d == STM) || (state_d == WAIT_FINISH);

    // State, status and output-array registers. stmActive_q always equals the
    // source of state_q, so comparing it with srcStm_d detects a source change
    // on the edge where it happens and raises switch_q for the following cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= NORMAL;
            stmActive_q <= 1'b0;
            switch_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                duty_q[i]  <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            stmActive_q <= srcStm_d;
            switch_q    <= (srcStm_d != stmActive_q);
            for (int i = 0; i < DEPTH; i++) begin
                duty_q[i]  <= srcStm_d ? bus.dutyStm[i]  : bus.dutyNormal[i];
                phase_q[i] <= srcStm_d ? bus.phaseStm[i] : bus.phaseNormal[i];
            end
        end
    end

    assign bus.duty        = duty_q;
    assign bus.phase       = phase_q;
    assign bus.stmActive   = stmActive_q;
    assign bus.switchPulse = switch_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_stm_source_switcher.sv
// ---------------------------------------------------------------------------
// tb_stm_source_switcher
//
// Directed testbench for stm_source_switcher. Each scenario task drives its
// own stimulus and checks state, status flags and the full output arrays
// against values worked out by hand for that scenario.
// ---------------------------------------------------------------------------
module tb_stm_source_switcher;

    localparam int WIDTH = 13;
    localparam int DEPTH = 249;
    localparam int IDX_W = 16;

    localparam int SRC_NORMAL = 0;
    localparam int SRC_STM    = 1;
    localparam int SRC_ZERO   = 2;

    logic clk;
    logic reset;
    int   assertCount = 0;
    int   failCount   = 0;
    int   n;

    stm_source_switcher_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    stm_source_switcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fill the four input arrays with patterns that differ between the normal
    // and STM sets on every channel, and are non-zero on every channel.
    task automatic setPattern(input int seed);
        for (int i = 0; i < DEPTH; i++) begin
            bus.dutyNormal[i]  = WIDTH'(i * 3  + seed);
            bus.phaseNormal[i] = WIDTH'(i * 5  + seed + 1);
            bus.dutyStm[i]     = WIDTH'(i * 7  + seed + 2);
            bus.phaseStm[i]    = WIDTH'(i * 11 + seed + 3);
        end
    endtask

    // Number of channels whose duty or phase differs from the chosen source.
    function automatic int countMismatch(input int src);
        int cnt;
        logic [WIDTH-1:0] expDuty;
        logic [WIDTH-1:0] expPhase;
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            case (src)
                SRC_NORMAL: begin expDuty = bus.dutyNormal[i]; expPhase = bus.phaseNormal[i]; end
                SRC_STM:    begin expDuty = bus.dutyStm[i];    expPhase = bus.phaseStm[i];    end
                default:    begin expDuty = '0;                expPhase = '0;                 end
            endcase
            if (bus.duty[i] !== expDuty || bus.phase[i] !== expPhase) cnt++;
        end
        return cnt;
    endfunction

    // Advance one edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseIdx(input int idx);
        bus.stmDone = 1'b1;
        bus.stmIdx  = IDX_W'(idx);
        step();
        bus.stmDone = 1'b0;
    endtask

    // Reset with non-zero input arrays: everything must read zero.
    task automatic test_reset();
        reset = 1'b1;
        bus.opMode = 1'b0; bus.useStartIdx = 1'b0; bus.startIdx = '0;
        bus.useFinishIdx = 1'b0; bus.finishIdx = '0;
        bus.stmDone = 1'b0; bus.stmIdx = '0;
        setPattern(1);
        repeat (2) step();
        assertCount++;
        if (bus.state !== 2'd0) begin failCount++; $display("[TB] FAIL reset_state actual=%0d required=0", bus.state); end
        assertCount++;
        if (bus.stmActive !== 1'b0) begin failCount++; $display("[TB] FAIL reset_active actual=%b required=0", bus.stmActive); end
        assertCount++;
        if (bus.switchPulse !== 1'b0) begin failCount++; $display("[TB] FAIL reset_switch actual=%b required=0", bus.switchPulse); end
        n = countMismatch(SRC_ZERO);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL reset_outputs nonzero_channels=%0d required=0", n); end
        reset = 1'b0;
        step();
        n = countMismatch(SRC_NORMAL);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL idle_normal_data bad_channels=%0d required=0", n); end
    endtask

    // Ungated entry and ungated exit, one edge each.
    task automatic test_direct_entry();
        bus.opMode = 1'b1; bus.useStartIdx = 1'b0;
        step();
        assertCount++;
        if (bus.state !== 2'd2) begin failCount++; $display("[TB] FAIL direct_state actual=%0d required=2", bus.state); end
        assertCount++;
        if (bus.stmActive !== 1'b1 || bus.switchPulse !== 1'b1) begin failCount++; $display("[TB] FAIL direct_flags actual=%b%b required=11", bus.stmActive, bus.switchPulse); end
        n = countMismatch(SRC_STM);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL direct_stm_data bad_channels=%0d required=0", n); end
        step();
        assertCount++;
        if (bus.switchPulse !== 1'b0 || bus.state !== 2'd2) begin failCount++; $display("[TB] FAIL direct_hold actual=%b/%0d required=0/2", bus.switchPulse, bus.state); end
        // Data latency: a new STM pattern shows up after one edge.
        setPattern(40);
        step();
        n = countMismatch(SRC_STM);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL stm_data_latency bad_channels=%0d required=0", n); end
        bus.opMode = 1'b0; bus.useFinishIdx = 1'b0;
        step();
        assertCount++;
        if (bus.state !== 2'd0 || bus.switchPulse !== 1'b1 || bus.stmActive !== 1'b0) begin failCount++; $display("[TB] FAIL direct_exit actual=%0d/%b/%b required=0/1/0", bus.state, bus.switchPulse, bus.stmActive); end
        n = countMismatch(SRC_NORMAL);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL direct_exit_data bad_channels=%0d required=0", n); end
        step();
    endtask

    // Entry gated on start index 5.
    task automatic test_start_idx();
        setPattern(100);
        bus.useStartIdx = 1'b1; bus.startIdx = 16'd5; bus.opMode = 1'b1;
        step();
        assertCount++;
        if (bus.state !== 2'd1 || bus.stmActive !== 1'b0 || bus.switchPulse !== 1'b0) begin failCount++; $display("[TB] FAIL start_wait actual=%0d/%b/%b required=1/0/0", bus.state, bus.stmActive, bus.switchPulse); end
        pulseIdx(3);
        pulseIdx(4);
        assertCount++;
        if (bus.state !== 2'd1) begin failCount++; $display("[TB] FAIL start_no_hit actual=%0d required=1", bus.state); end
        n = countMismatch(SRC_NORMAL);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL start_wait_data bad_channels=%0d required=0", n); end
        // Matching index without stmDone must not count as a hit.
        bus.stmIdx = 16'd5;
        step();
        assertCount++;
        if (bus.state !== 2'd1) begin failCount++; $display("[TB] FAIL start_idx_no_done actual=%0d required=1", bus.state); end
        pulseIdx(5);
        assertCount++;
        if (bus.state !== 2'd2 || bus.switchPulse !== 1'b1 || bus.stmActive !== 1'b1) begin failCount++; $display("[TB] FAIL start_hit actual=%0d/%b/%b required=2/1/1", bus.state, bus.switchPulse, bus.stmActive); end
        n = countMismatch(SRC_STM);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL start_hit_data bad_channels=%0d required=0", n); end
        bus.opMode = 1'b0; bus.useFinishIdx = 1'b0;
        step();
        // Unreachable start index, released by clearing useStartIdx.
        bus.startIdx = 16'd600; bus.opMode = 1'b1;
        step();
        pulseIdx(0);
        pulseIdx(1);
        assertCount++;
        if (bus.state !== 2'd1) begin failCount++; $display("[TB] FAIL start_unreachable actual=%0d required=1", bus.state); end
        bus.useStartIdx = 1'b0;
        step();
        assertCount++;
        if (bus.state !== 2'd2 || bus.switchPulse !== 1'b1) begin failCount++; $display("[TB] FAIL start_gate_cleared actual=%0d/%b required=2/1", bus.state, bus.switchPulse); end
    endtask

    // Exit gated on finish index 0 (starts in STM from the previous task).
    task automatic test_finish_idx();
        setPattern(200);
        bus.useFinishIdx = 1'b1; bus.finishIdx = 16'd0; bus.opMode = 1'b0;
        step();
        assertCount++;
        if (bus.state !== 2'd3 || bus.stmActive !== 1'b1 || bus.switchPulse !== 1'b0) begin failCount++; $display("[TB] FAIL finish_wait actual=%0d/%b/%b required=3/1/0", bus.state, bus.stmActive, bus.switchPulse); end
        n = countMismatch(SRC_STM);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL finish_wait_data bad_channels=%0d required=0", n); end
        pulseIdx(7);
        assertCount++;
        if (bus.state !== 2'd3) begin failCount++; $display("[TB] FAIL finish_no_hit actual=%0d required=3", bus.state); end
        pulseIdx(0);
        assertCount++;
        if (bus.state !== 2'd0 || bus.switchPulse !== 1'b1 || bus.stmActive !== 1'b0) begin failCount++; $display("[TB] FAIL finish_hit actual=%0d/%b/%b required=0/1/0", bus.state, bus.switchPulse, bus.stmActive); end
        n = countMismatch(SRC_NORMAL);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL finish_hit_data bad_channels=%0d required=0", n); end
        step();
    endtask

    // Exit cancelled by raising opMode in WAIT_FINISH, then released by
    // clearing useFinishIdx.
    task automatic test_cancel_exit();
        bus.useStartIdx = 1'b0; bus.opMode = 1'b1;
        step();
        bus.useFinishIdx = 1'b1; bus.finishIdx = 16'd100; bus.opMode = 1'b0;
        step();
        step();
        assertCount++;
        if (bus.state !== 2'd3) begin failCount++; $display("[TB] FAIL cancel_wait actual=%0d required=3", bus.state); end
        bus.opMode = 1'b1;
        step();
        assertCount++;
        if (bus.state !== 2'd2 || bus.switchPulse !== 1'b0 || bus.stmActive !== 1'b1) begin failCount++; $display("[TB] FAIL cancel_back actual=%0d/%b/%b required=2/0/1", bus.state, bus.switchPulse, bus.stmActive); end
        bus.opMode = 1'b0;
        step();
        bus.useFinishIdx = 1'b0;
        step();
        assertCount++;
        if (bus.state !== 2'd0 || bus.switchPulse !== 1'b1) begin failCount++; $display("[TB] FAIL finish_gate_cleared actual=%0d/%b required=0/1", bus.state, bus.switchPulse); end
        step();
    endtask

    // Simultaneous opMode drop with an index hit.
    task automatic test_simultaneous();
        bus.useStartIdx = 1'b1; bus.startIdx = 16'd9; bus.opMode = 1'b1;
        step();
        bus.opMode = 1'b0;
        pulseIdx(9);
        assertCount++;
        if (bus.state !== 2'd0 || bus.stmActive !== 1'b0 || bus.switchPulse !== 1'b0) begin failCount++; $display("[TB] FAIL sim_start actual=%0d/%b/%b required=0/0/0", bus.state, bus.stmActive, bus.switchPulse); end
        bus.useStartIdx = 1'b0; bus.opMode = 1'b1;
        step();
        bus.useFinishIdx = 1'b1; bus.finishIdx = 16'd12; bus.opMode = 1'b0;
        pulseIdx(12);
        assertCount++;
        if (bus.state !== 2'd0 || bus.switchPulse !== 1'b1) begin failCount++; $display("[TB] FAIL sim_finish actual=%0d/%b required=0/1", bus.state, bus.switchPulse); end
        bus.useFinishIdx = 1'b0;
        step();
    endtask

    // NORMAL -> STM -> NORMAL on consecutive edges gives two pulses.
    task automatic test_back_to_back();
        bus.useStartIdx = 1'b0; bus.useFinishIdx = 1'b0; bus.opMode = 1'b1;
        step();
        assertCount++;
        if (bus.state !== 2'd2 || bus.switchPulse !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_first actual=%0d/%b required=2/1", bus.state, bus.switchPulse); end
        bus.opMode = 1'b0;
        step();
        assertCount++;
        if (bus.state !== 2'd0 || bus.switchPulse !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_second actual=%0d/%b required=0/1", bus.state, bus.switchPulse); end
        step();
        assertCount++;
        if (bus.switchPulse !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_quiet actual=%b required=0", bus.switchPulse); end
    endtask

    // Reset while in STM, then release with opMode still high.
    task automatic test_reset_mid();
        setPattern(300);
        bus.opMode = 1'b1;
        step();
        reset = 1'b1;
        step();
        assertCount++;
        if (bus.state !== 2'd0 || bus.stmActive !== 1'b0 || bus.switchPulse !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_flags actual=%0d/%b/%b required=0/0/0", bus.state, bus.stmActive, bus.switchPulse); end
        n = countMismatch(SRC_ZERO);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL midreset_outputs nonzero_channels=%0d required=0", n); end
        reset = 1'b0;
        step();
        assertCount++;
        if (bus.state !== 2'd2 || bus.stmActive !== 1'b1 || bus.switchPulse !== 1'b1) begin failCount++; $display("[TB] FAIL midreset_reentry actual=%0d/%b/%b required=2/1/1", bus.state, bus.stmActive, bus.switchPulse); end
        n = countMismatch(SRC_STM);
        assertCount++;
        if (n !== 0) begin failCount++; $display("[TB] FAIL midreset_stm_data bad_channels=%0d required=0", n); end
    endtask

    // Run every scenario in order and report.
    initial begin
        test_reset();
        test_direct_entry();
        test_start_idx();
        test_finish_idx();
        test_cancel_exit();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
